// File: rtl/cam_ctrl.sv
// -----------------------------------------------------------------------------
// cam_ctrl
//
// Sequenced access controller for a content-addressable memory array. A request
// (READ, WRITE, SEARCH, INVALIDATE) is accepted over a valid/ready handshake.
// The controller then drives registered one-hot per-entry enables into the
// array for one cycle and samples the array's result one cycle later. It
// returns exactly one response per request over a second valid/ready
// handshake. A valid bit per entry is tracked locally. Search matches are
// masked by those valid bits and priority-encoded, with the lowest index
// winning.
//
// Ports
//   clk_i, reset_i        rising-edge clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake; ready only when idle
//   req_op_i              00 READ, 01 WRITE, 10 SEARCH, 11 INVALIDATE
//   req_addr_i            entry index (ignored for SEARCH)
//   req_data_i            write data or search key
//   write/read/search_enable_o  per-entry array strobes (ISSUE cycle only)
//   array_data_o          write data / search key presented to the array
//   read_data_i, match_i  array results, valid the cycle after the strobe
//   rsp_valid_o/ready_i   response handshake
//   rsp_hit_o, rsp_addr_o, rsp_data_o   response fields
//   count_o, full_o       number of valid entries, all entries valid
// -----------------------------------------------------------------------------
module cam_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic [DEPTH-1:0]      write_enable_o,
    output logic [DEPTH-1:0]      read_enable_o,
    output logic [DEPTH-1:0]      search_enable_o,
    output logic [DATA_WIDTH-1:0] array_data_o,
    input  logic [DATA_WIDTH-1:0] read_data_i,
    input  logic [DEPTH-1:0]      match_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_hit_o,
    output logic [ADDR_WIDTH-1:0] rsp_addr_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SEARCH, OP_INVAL} op_t;

    state_t                  state_q, state_d;
    op_t                     op_q, op_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    old_valid_q, old_valid_d;
    logic [DEPTH-1:0]        wr_en_q, wr_en_d;
    logic [DEPTH-1:0]        rd_en_q, rd_en_d;
    logic [DEPTH-1:0]        se_en_q, se_en_d;
    logic                    rsp_hit_q, rsp_hit_d;
    logic [ADDR_WIDTH-1:0]   rsp_addr_q, rsp_addr_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    logic                    accept;
    logic [DEPTH-1:0]        req_one_hot;
    logic [DEPTH-1:0]        masked_match;

    // Lowest set index wins; scanning downward lets the last hit overwrite.
    function automatic logic [ADDR_WIDTH-1:0] lowest_index(input logic [DEPTH-1:0] m);
        lowest_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m[i]) lowest_index = ADDR_WIDTH'(i);
        end
    endfunction

    assign accept       = req_valid_i && (state_q == IDLE);
    assign req_one_hot  = {{(DEPTH-1){1'b0}}, 1'b1} << req_addr_i;
    assign masked_match = match_i & valid_q;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready_o = (state_q == IDLE);
        rsp_valid_o = (state_q == RESP);
    end

    // ---------------- Datapath next-state ----------------
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        count_d     = count_q;
        old_valid_d = old_valid_q;
        wr_en_d     = '0;
        rd_en_d     = '0;
        se_en_d     = '0;
        rsp_hit_d   = rsp_hit_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;

        // Enables are computed from the request itself so the registered
        // strobes are high exactly for the ISSUE cycle.
        if (accept) begin
            op_d   = op_t'(req_op_i);
            addr_d = req_addr_i;
            data_d = req_data_i;
            case (op_t'(req_op_i))
                OP_WRITE:  wr_en_d = req_one_hot;
                OP_READ:   rd_en_d = req_one_hot;
                OP_SEARCH: se_en_d = valid_q;
                default:   ;
            endcase
        end

        if (state_q == ISSUE) begin
            case (op_q)
                OP_WRITE: begin
                    valid_d[addr_q] = 1'b1;
                    if (!valid_q[addr_q]) count_d = count_q + 1'b1;
                end
                OP_INVAL: begin
                    old_valid_d     = valid_q[addr_q];
                    valid_d[addr_q] = 1'b0;
                    if (valid_q[addr_q]) count_d = count_q - 1'b1;
                end
                default: ;
            endcase
        end

        if (state_q == CAPTURE) begin
            case (op_q)
                OP_READ: begin
                    rsp_hit_d  = valid_q[addr_q];
                    rsp_addr_d = addr_q;
                    rsp_data_d = read_data_i;
                end
                OP_SEARCH: begin
                    rsp_hit_d  = |masked_match;
                    rsp_addr_d = lowest_index(masked_match);
                    rsp_data_d = data_q;
                end
                OP_WRITE: begin
                    rsp_hit_d  = 1'b1;
                    rsp_addr_d = addr_q;
                    rsp_data_d = data_q;
                end
                default: begin
                    rsp_hit_d  = old_valid_q;
                    rsp_addr_d = addr_q;
                    rsp_data_d = '0;
                end
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    // NOTE: the valid vector is reset because it is control state; entry
    // contents live in the array and are never reset here.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            op_q        <= OP_READ;
            addr_q      <= '0;
            data_q      <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            old_valid_q <= 1'b0;
            wr_en_q     <= '0;
            rd_en_q     <= '0;
            se_en_q     <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
        end else begin
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            old_valid_q <= old_valid_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            se_en_q     <= se_en_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign write_enable_o  = wr_en_q;
    assign read_enable_o   = rd_en_q;
    assign search_enable_o = se_en_q;
    assign array_data_o    = data_q;
    assign rsp_hit_o       = rsp_hit_q;
    assign rsp_addr_o      = rsp_addr_q;
    assign rsp_data_o      = rsp_data_q;
    assign count_o         = count_q;
    assign full_o          = (count_q == (ADDR_WIDTH + 1)'(DEPTH));

endmodule

// File: doc/cam_ctrl.md
# cam_ctrl

Sequenced access controller for the content-addressable memory, replacing the purely combinational address decoder. Accepts read, write, search and invalidate requests over a valid/ready handshake and drives one-hot per-entry enables into the CAM array. Tracks a valid bit per entry, masks and priority-encodes the array's match vector, and returns one response per request over a second valid/ready handshake. Sits between the requesting logic and the CAM storage array.

## Interface
- DATA_WIDTH, 32, entry/key width in bits
- ADDR_WIDTH, 5, entry index width
- DEPTH, 1<<ADDR_WIDTH, number of entries
- clk_i  in  1  clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  controller can accept a request
- req_op_i  in  2  00 READ, 01 WRITE, 10 SEARCH, 11 INVALIDATE
- req_addr_i  in  ADDR_WIDTH  entry index (READ/WRITE/INVALIDATE; ignored for SEARCH)
- req_data_i  in  DATA_WIDTH  write data or search key
- write_enable_o  out  DEPTH  one-hot array write strobe
- read_enable_o  out  DEPTH  one-hot array read strobe
- search_enable_o  out  DEPTH  per-entry compare enable
- array_data_o  out  DATA_WIDTH  write data / key to array
- read_data_i  in  DATA_WIDTH  array read data, valid the cycle after read_enable_o
- match_i  in  DEPTH  array match vector, valid the cycle after search_enable_o
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_hit_o  out  1  hit / entry-valid result
- rsp_addr_o  out  ADDR_WIDTH  result index
- rsp_data_o  out  DATA_WIDTH  read data or echoed key
- count_o  out  ADDR_WIDTH+1  number of valid entries
- full_o  out  1  count_o == DEPTH

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. req_ready_o = (state == IDLE).
- IDLE: on req_valid_i && req_ready_o, latch op/addr/data, go to ISSUE.
- ISSUE (exactly 1 cycle): array_data_o = latched data.
  - WRITE: write_enable_o = one-hot(addr); set valid[addr].
  - READ: read_enable_o = one-hot(addr).
  - SEARCH: search_enable_o = valid vector (only valid entries compare).
  - INVALIDATE: no enables; record old valid[addr], clear valid[addr].
  - Go to CAPTURE.
- CAPTURE (1 cycle): all enables 0. At the closing edge register the results and go to RESP:
  - READ: hit = valid[addr], data = read_data_i, rsp_addr = addr.
  - SEARCH: m = match_i & valid; hit = |m; rsp_addr = lowest set index of m (0 if none); data = key.
  - WRITE: hit = 1, rsp_addr = addr, data = written data.
  - INVALIDATE: hit = recorded old valid bit, rsp_addr = addr, data = 0.
- RESP: rsp_valid_o held high and response fields stable until rsp_ready_i; on the handshake edge go to IDLE.
- count_o: +1 on a WRITE to an invalid entry; -1 on an INVALIDATE of a valid entry; unchanged otherwise (rewrite, double invalidate). Never wraps; range 0..DEPTH.
- Search with multiple matches: lowest index wins. Match bits of invalid entries are ignored even if the array asserts them.
- WRITE when full_o = 1 is permitted only as an overwrite; addressing is explicit, so there is no overflow case.

## Timing
- Reset (async assert, sync-clean release): state IDLE, valid vector 0, req_ready_o = 1, all other outputs 0 (count_o = 0, full_o = 0, rsp fields 0, all enables 0).
- Reset mid-operation aborts the in-flight request with no response; enables drop immediately on assertion.
- Request accepted at edge k: enables high during cycle k..k+1, array result sampled at edge k+2, rsp_valid_o high from edge k+2.
- With rsp_ready_i held high, the response handshake is at edge k+3 and req_ready_o is high again after k+3. Minimum 3 cycles per request; no overlap.
- Valid-bit and count_o updates are visible from edge k+1.
- Enables are registered (glitch-free) and never asserted outside ISSUE.

## Test plan
- Reset, then WRITE addr 3 data 0xDEADBEEF -> write_enable_o = 0x00000008 for one cycle; rsp_hit_o = 1, rsp_addr_o = 3; count_o = 1.
- READ addr 3 with read_data_i = 0xDEADBEEF -> read_enable_o = 0x8; rsp_hit_o = 1, rsp_data_o = 0xDEADBEEF. READ addr 4 -> rsp_hit_o = 0.
- Valid entries 2, 5, 9; SEARCH with match_i = 0x00000224 -> search_enable_o = 0x00000224, rsp_hit_o = 1, rsp_addr_o = 2. Same search with match_i = 0x00000010 (entry 4 invalid) -> rsp_hit_o = 0.
- INVALIDATE addr 5 twice -> rsp_hit_o = 1 then 0; count_o decrements once (3 -> 2).
- Hold rsp_ready_i low for 5 cycles -> rsp_valid_o and all fields stable, req_ready_o = 0; a req_valid_i pulse during the stall is not accepted.
- Write all 32 entries -> full_o = 1, count_o = 32. Assert reset_i during ISSUE of the next request -> enables 0 immediately, count_o = 0, no response, req_ready_o = 1.
